// File: rtl/sirv_tl_fragmenter_8_pkg.sv
// Shared definitions for the 1-byte TileLink-UL fragmenter: field widths,
// opcode encodings, bus payload structs and a beat-count helper.
package sirv_tl_fragmenter_8_pkg;

  localparam int unsigned OPCODE_W  = 3;
  localparam int unsigned PARAM_W   = 3;
  localparam int unsigned SIZE_W    = 3;
  localparam int unsigned SOURCE_W  = 2;
  localparam int unsigned ADDR_W    = 30;
  localparam int unsigned MASK_W    = 1;
  localparam int unsigned DATA_W    = 8;
  localparam int unsigned D_PARAM_W = 2;
  localparam int unsigned NUM_SRC   = 1 << SOURCE_W;
  // Wide enough to hold (1 << size) - 1 for any 3-bit size.
  localparam int unsigned BEAT_W    = 8;

  // A-channel opcodes
  localparam logic [OPCODE_W-1:0] OP_PUT_FULL    = 3'd0;
  localparam logic [OPCODE_W-1:0] OP_PUT_PARTIAL = 3'd1;
  localparam logic [OPCODE_W-1:0] OP_ARITH       = 3'd2;
  localparam logic [OPCODE_W-1:0] OP_LOGIC       = 3'd3;
  localparam logic [OPCODE_W-1:0] OP_GET         = 3'd4;
  localparam logic [OPCODE_W-1:0] OP_HINT        = 3'd5;
  // D-channel opcodes
  localparam logic [OPCODE_W-1:0] OP_ACK         = 3'd0;
  localparam logic [OPCODE_W-1:0] OP_ACK_DATA    = 3'd1;

  typedef struct packed {
    logic [OPCODE_W-1:0] opcode;
    logic [PARAM_W-1:0]  param;
    logic [SIZE_W-1:0]   size;
    logic [SOURCE_W-1:0] source;
    logic [ADDR_W-1:0]   address;
    logic [MASK_W-1:0]   mask;
    logic [DATA_W-1:0]   data;
  } tl_a_t;

  typedef struct packed {
    logic [OPCODE_W-1:0]  opcode;
    logic [D_PARAM_W-1:0] param;
    logic [SIZE_W-1:0]    size;
    logic [SOURCE_W-1:0]  source;
    logic [DATA_W-1:0]    data;
    logic                 error;
  } tl_d_t;

  // Index of the last beat of a message of 2^size bytes.
  function automatic logic [BEAT_W-1:0] beats_m1(input logic [SIZE_W-1:0] size);
    return (BEAT_W'(1) << size) - BEAT_W'(1);
  endfunction

endpackage

// File: rtl/sirv_tl_frag_dtrack.sv
// Per-source response tracking for the fragmenter.
// A side: records the original request size on the first fragment.
// D side: looks up size / last-beat / sticky error for d_source and advances
// the beat counter and sticky error on accepted beats.
// Ports: clock, reset; a_wr_en/a_wr_source/a_wr_size (table write);
// d_source, d_fire, d_err_set, d_err_clr (D update); d_size_c, d_last_c,
// d_err_c (combinational lookups).
module sirv_tl_frag_dtrack
  import sirv_tl_fragmenter_8_pkg::*;
#(
  parameter int unsigned MAX_LOG = 3
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                a_wr_en,
  input  logic [SOURCE_W-1:0] a_wr_source,
  input  logic [SIZE_W-1:0]   a_wr_size,
  input  logic [SOURCE_W-1:0] d_source,
  input  logic                d_fire,
  input  logic                d_err_set,
  input  logic                d_err_clr,
  output logic [SIZE_W-1:0]   d_size_c,
  output logic                d_last_c,
  output logic                d_err_c
);

  logic [SIZE_W-1:0]  size_tab [NUM_SRC];
  logic [MAX_LOG-1:0] d_cnt    [NUM_SRC];
  logic [NUM_SRC-1:0] err_tab;

  // D-side lookup; reads pre-write table contents
  always_comb begin
    d_size_c = size_tab[d_source];
    d_last_c = (BEAT_W'(d_cnt[d_source]) == beats_m1(size_tab[d_source]));
    d_err_c  = err_tab[d_source];
  end

  // Table and counter updates
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int unsigned i = 0; i < NUM_SRC; i++) begin
        size_tab[i] <= '0;
        d_cnt[i]    <= '0;
      end
      err_tab <= '0;
    end else begin
      if (a_wr_en) begin
        size_tab[a_wr_source] <= a_wr_size;
      end
      if (d_fire) begin
        d_cnt[d_source] <= d_last_c ? '0 : d_cnt[d_source] + MAX_LOG'(1);
      end
      if (d_err_clr) begin
        err_tab[d_source] <= 1'b0;
      end else if (d_err_set) begin
        err_tab[d_source] <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/sirv_tl_fragmenter_8.sv
// TileLink-UL fragmenter control stage for a 1-byte peripheral bus.
// A channel: zero-latency forward, fragments to size 0 with incrementing
// address; rpt asks the upstream repeater to re-present a Get beat.
// D channel: coalesces AccessAck beats into one response per message and
// restores the original size on every response.
// Ports: clock/reset; rpt; in_* (A in); out_* (A out); d_in_* (D in);
// d_out_* (D out).
module sirv_tl_fragmenter_8
  import sirv_tl_fragmenter_8_pkg::*;
#(
  parameter int unsigned MAX_LOG = 3
) (
  input  logic                 clock,
  input  logic                 reset,
  output logic                 rpt,
  output logic                 in_ready,
  input  logic                 in_valid,
  input  logic [OPCODE_W-1:0]  in_bits_opcode,
  input  logic [PARAM_W-1:0]   in_bits_param,
  input  logic [SIZE_W-1:0]    in_bits_size,
  input  logic [SOURCE_W-1:0]  in_bits_source,
  input  logic [ADDR_W-1:0]    in_bits_address,
  input  logic [MASK_W-1:0]    in_bits_mask,
  input  logic [DATA_W-1:0]    in_bits_data,
  input  logic                 out_ready,
  output logic                 out_valid,
  output logic [OPCODE_W-1:0]  out_bits_opcode,
  output logic [PARAM_W-1:0]   out_bits_param,
  output logic [SIZE_W-1:0]    out_bits_size,
  output logic [SOURCE_W-1:0]  out_bits_source,
  output logic [ADDR_W-1:0]    out_bits_address,
  output logic [MASK_W-1:0]    out_bits_mask,
  output logic [DATA_W-1:0]    out_bits_data,
  output logic                 d_in_ready,
  input  logic                 d_in_valid,
  input  logic [OPCODE_W-1:0]  d_in_bits_opcode,
  input  logic [D_PARAM_W-1:0] d_in_bits_param,
  input  logic [SIZE_W-1:0]    d_in_bits_size,
  input  logic [SOURCE_W-1:0]  d_in_bits_source,
  input  logic [DATA_W-1:0]    d_in_bits_data,
  input  logic                 d_in_bits_error,
  input  logic                 d_out_ready,
  output logic                 d_out_valid,
  output logic [OPCODE_W-1:0]  d_out_bits_opcode,
  output logic [D_PARAM_W-1:0] d_out_bits_param,
  output logic [SIZE_W-1:0]    d_out_bits_size,
  output logic [SOURCE_W-1:0]  d_out_bits_source,
  output logic [DATA_W-1:0]    d_out_bits_data,
  output logic                 d_out_bits_error
);

  logic [MAX_LOG-1:0] a_cnt;
  logic               a_is_get_c;
  logic               a_is_put_c;
  logic [SIZE_W-1:0]  a_eff_size_c;
  logic               a_last_c;
  logic               out_fire_c;
  tl_a_t              a_out_c;

  logic               d_is_ack_c;
  logic               d_drop_c;
  logic               d_fire_c;
  logic               d_err_set_c;
  logic               d_err_clr_c;
  logic [SIZE_W-1:0]  d_size_c;
  logic               d_last_c;
  logic               d_err_c;
  tl_d_t              d_out_c;

  // A-side fragment decode; atomics and hints are single fragments
  always_comb begin
    a_is_get_c   = (in_bits_opcode == OP_GET);
    a_is_put_c   = (in_bits_opcode == OP_PUT_FULL) || (in_bits_opcode == OP_PUT_PARTIAL);
    a_eff_size_c = (a_is_get_c || a_is_put_c) ? in_bits_size : '0;
    a_last_c     = (BEAT_W'(a_cnt) == beats_m1(a_eff_size_c));
    out_fire_c   = in_valid & out_ready;

    a_out_c         = '0;
    a_out_c.opcode  = in_bits_opcode;
    a_out_c.param   = in_bits_param;
    a_out_c.size    = '0;
    a_out_c.source  = in_bits_source;
    a_out_c.address = in_bits_address
                    | ADDR_W'(BEAT_W'(a_cnt) & beats_m1(a_eff_size_c));
    a_out_c.mask    = in_bits_mask;
    a_out_c.data    = in_bits_data;
  end

  assign out_valid        = in_valid;
  assign in_ready         = out_ready;
  assign rpt              = in_valid & a_is_get_c & ~a_last_c;
  assign out_bits_opcode  = a_out_c.opcode;
  assign out_bits_param   = a_out_c.param;
  assign out_bits_size    = a_out_c.size;
  assign out_bits_source  = a_out_c.source;
  assign out_bits_address = a_out_c.address;
  assign out_bits_mask    = a_out_c.mask;
  assign out_bits_data    = a_out_c.data;

  // Fragment counter within the current message
  always_ff @(posedge clock) begin
    if (reset) begin
      a_cnt <= '0;
    end else if (out_fire_c) begin
      a_cnt <= a_last_c ? '0 : a_cnt + MAX_LOG'(1);
    end
  end

  sirv_tl_frag_dtrack #(
    .MAX_LOG (MAX_LOG)
  ) u_dtrack (
    .clock       (clock),
    .reset       (reset),
    .a_wr_en     (out_fire_c & (a_cnt == '0)),
    .a_wr_source (in_bits_source),
    .a_wr_size   (in_bits_size),
    .d_source    (d_in_bits_source),
    .d_fire      (d_fire_c),
    .d_err_set   (d_err_set_c),
    .d_err_clr   (d_err_clr_c),
    .d_size_c    (d_size_c),
    .d_last_c    (d_last_c),
    .d_err_c     (d_err_c)
  );

  // D-side: swallow non-last AccessAck beats, fold their errors into the last
  always_comb begin
    d_is_ack_c  = (d_in_bits_opcode == OP_ACK);
    d_drop_c    = d_is_ack_c & ~d_last_c;
    d_fire_c    = d_in_valid & (d_drop_c | d_out_ready);
    d_err_set_c = d_fire_c & d_drop_c & d_in_bits_error;
    d_err_clr_c = d_fire_c & d_is_ack_c & d_last_c;

    d_out_c        = '0;
    d_out_c.opcode = d_in_bits_opcode;
    d_out_c.param  = d_in_bits_param;
    d_out_c.size   = d_size_c;
    d_out_c.source = d_in_bits_source;
    d_out_c.data   = d_in_bits_data;
    d_out_c.error  = d_in_bits_error | (d_is_ack_c & d_err_c);
  end

  // Incoming D size is always 0 on this bus; the restored size replaces it.
  logic d_in_size_unused_c;
  assign d_in_size_unused_c = ^d_in_bits_size;

  assign d_in_ready        = d_drop_c | d_out_ready;
  assign d_out_valid       = d_in_valid & ~d_drop_c;
  assign d_out_bits_opcode = d_out_c.opcode;
  assign d_out_bits_param  = d_out_c.param;
  assign d_out_bits_size   = d_out_c.size;
  assign d_out_bits_source = d_out_c.source;
  assign d_out_bits_data   = d_out_c.data;
  assign d_out_bits_error  = d_out_c.error;

endmodule

// File: tb/tb_sirv_tl_fragmenter_8.sv
// Self-checking bench for sirv_tl_fragmenter_8 against a message-level model.
module tb_sirv_tl_fragmenter_8;

  logic        clock;
  logic        reset;
  logic        rpt;
  logic        in_ready;
  logic        in_valid;
  logic [2:0]  in_bits_opcode;
  logic [2:0]  in_bits_param;
  logic [2:0]  in_bits_size;
  logic [1:0]  in_bits_source;
  logic [29:0] in_bits_address;
  logic        in_bits_mask;
  logic [7:0]  in_bits_data;
  logic        out_ready;
  logic        out_valid;
  logic [2:0]  out_bits_opcode;
  logic [2:0]  out_bits_param;
  logic [2:0]  out_bits_size;
  logic [1:0]  out_bits_source;
  logic [29:0] out_bits_address;
  logic        out_bits_mask;
  logic [7:0]  out_bits_data;
  logic        d_in_ready;
  logic        d_in_valid;
  logic [2:0]  d_in_bits_opcode;
  logic [1:0]  d_in_bits_param;
  logic [2:0]  d_in_bits_size;
  logic [1:0]  d_in_bits_source;
  logic [7:0]  d_in_bits_data;
  logic        d_in_bits_error;
  logic        d_out_ready;
  logic        d_out_valid;
  logic [2:0]  d_out_bits_opcode;
  logic [1:0]  d_out_bits_param;
  logic [2:0]  d_out_bits_size;
  logic [1:0]  d_out_bits_source;
  logic [7:0]  d_out_bits_data;
  logic        d_out_bits_error;

  int checks   = 0;
  int failures = 0;

  // Message-level model: request size per source, response beats seen so far
  // in the current message, and errors collected from swallowed acks.
  int exp_size [4];
  int seen     [4];
  bit acc_err  [4];

  sirv_tl_fragmenter_8 #(.MAX_LOG(3)) dut (
    .clock             (clock),
    .reset             (reset),
    .rpt               (rpt),
    .in_ready          (in_ready),
    .in_valid          (in_valid),
    .in_bits_opcode    (in_bits_opcode),
    .in_bits_param     (in_bits_param),
    .in_bits_size      (in_bits_size),
    .in_bits_source    (in_bits_source),
    .in_bits_address   (in_bits_address),
    .in_bits_mask      (in_bits_mask),
    .in_bits_data      (in_bits_data),
    .out_ready         (out_ready),
    .out_valid         (out_valid),
    .out_bits_opcode   (out_bits_opcode),
    .out_bits_param    (out_bits_param),
    .out_bits_size     (out_bits_size),
    .out_bits_source   (out_bits_source),
    .out_bits_address  (out_bits_address),
    .out_bits_mask     (out_bits_mask),
    .out_bits_data     (out_bits_data),
    .d_in_ready        (d_in_ready),
    .d_in_valid        (d_in_valid),
    .d_in_bits_opcode  (d_in_bits_opcode),
    .d_in_bits_param   (d_in_bits_param),
    .d_in_bits_size    (d_in_bits_size),
    .d_in_bits_source  (d_in_bits_source),
    .d_in_bits_data    (d_in_bits_data),
    .d_in_bits_error   (d_in_bits_error),
    .d_out_ready       (d_out_ready),
    .d_out_valid       (d_out_valid),
    .d_out_bits_opcode (d_out_bits_opcode),
    .d_out_bits_param  (d_out_bits_param),
    .d_out_bits_size   (d_out_bits_size),
    .d_out_bits_source (d_out_bits_source),
    .d_out_bits_data   (d_out_bits_data),
    .d_out_bits_error  (d_out_bits_error)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Upstream never offers a size above MAX_LOG
  always @(posedge clock) begin
    if (!reset && in_valid === 1'b1) begin
      assert (in_bits_size <= 3'd3) else $error("size above MAX_LOG: %0d", in_bits_size);
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: bench did not finish, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  task automatic model_reset();
    for (int i = 0; i < 4; i++) begin
      exp_size[i] = 0;
      seen[i]     = 0;
      acc_err[i]  = 1'b0;
    end
  endtask

  task automatic apply_reset();
    @(negedge clock);
    reset      = 1'b1;
    in_valid   = 1'b0;
    d_in_valid = 1'b0;
    out_ready  = 1'b1;
    d_out_ready = 1'b1;
    repeat (2) @(negedge clock);
    reset = 1'b0;
    model_reset();
    #1;
    checks++;
    if ({rpt, out_valid, d_out_valid} !== 3'b000)
      begin failures++; $display("FAIL reset_idle: rpt/out_valid/d_out_valid=%b required 000", {rpt, out_valid, d_out_valid}); end
  endtask

  // Send one A message; mode 0 ready always, 1 toggling 1,0, 2 random.
  // max_frags stops early (to model an aborted message).
  task automatic send_msg(input logic [2:0] op, input logic [2:0] size, input logic [1:0] src,
                          input logic [29:0] base, input logic [7:0] d0, input int mode,
                          input int max_frags);
    int  n;
    int  k;
    int  cyc;
    bit  tog;
    bit  is_get;
    bit  rdy;
    bit  exp_rpt;
    logic [29:0] exp_addr;
    logic [7:0]  dat;
    logic [2:0]  prm;
    logic        msk;
    is_get = (op == 3'd4);
    n   = (op == 3'd4 || op == 3'd0 || op == 3'd1) ? (1 << size) : 1;
    if (max_frags < n) n = max_frags;
    k   = 0;
    cyc = 0;
    tog = 1'b1;
    prm = 3'($urandom);
    msk = 1'($urandom);
    while (k < n && cyc < 200) begin
      @(negedge clock);
      rdy = (mode == 0) ? 1'b1 : (mode == 1) ? tog : 1'($urandom);
      dat = is_get ? d0 : 8'(d0 + 8'(17 * k));
      in_valid        = 1'b1;
      in_bits_opcode  = op;
      in_bits_param   = prm;
      in_bits_size    = size;
      in_bits_source  = src;
      in_bits_address = base;
      in_bits_mask    = msk;
      in_bits_data    = dat;
      out_ready       = rdy;
      #1;
      exp_addr = base + 30'(k);
      exp_rpt  = is_get && (k != (1 << size) - 1);
      checks++;
      if ({out_valid, out_bits_address, out_bits_size, rpt, in_ready} !== {1'b1, exp_addr, 3'd0, exp_rpt, rdy})
        begin failures++; $display("FAIL a_frag op=%0d k=%0d: valid/addr/size/rpt/ready=%b/%h/%0d/%b/%b required 1/%h/0/%b/%b",
          op, k, out_valid, out_bits_address, out_bits_size, rpt, in_ready, exp_addr, exp_rpt, rdy); end
      checks++;
      if ({out_bits_opcode, out_bits_param, out_bits_source, out_bits_mask, out_bits_data} !== {op, prm, src, msk, dat})
        begin failures++; $display("FAIL a_pass k=%0d: got %h required %h", k,
          {out_bits_opcode, out_bits_param, out_bits_source, out_bits_mask, out_bits_data}, {op, prm, src, msk, dat}); end
      if (rdy) begin
        if (k == 0) exp_size[src] = int'(size);
        k++;
      end
      cyc++;
      tog = ~tog;
    end
    if (k < n) begin
      checks++; failures++;
      $display("FAIL a_timeout: %0d of %0d fragments sent", k, n);
    end
    @(negedge clock);
    in_valid = 1'b0;
    #1;
    checks++;
    if ({rpt, out_valid} !== 2'b00)
      begin failures++; $display("FAIL a_idle: rpt/out_valid=%b required 00", {rpt, out_valid}); end
  endtask

  // Present one D beat until accepted and check it against the model.
  task automatic d_beat(input logic [1:0] src, input logic [2:0] op, input logic err, input int mode);
    int  tries;
    int  nb;
    bit  last;
    bit  exp_v;
    bit  exp_r;
    bit  exp_e;
    bit  rdy;
    bit  done;
    logic [7:0] dat;
    logic [1:0] prm;
    tries = 0;
    done  = 1'b0;
    dat   = 8'($urandom);
    prm   = 2'($urandom);
    while (!done && tries < 32) begin
      @(negedge clock);
      rdy = (mode == 0) ? 1'b1 : 1'($urandom);
      d_in_valid       = 1'b1;
      d_in_bits_opcode = op;
      d_in_bits_param  = prm;
      d_in_bits_size   = 3'd0;
      d_in_bits_source = src;
      d_in_bits_data   = dat;
      d_in_bits_error  = err;
      d_out_ready      = rdy;
      #1;
      nb    = 1 << exp_size[src];
      last  = (seen[src] == nb - 1);
      exp_v = !(op == 3'd0 && !last);
      exp_r = exp_v ? rdy : 1'b1;
      exp_e = (op == 3'd0) ? (err | acc_err[src]) : err;
      checks++;
      if ({d_out_valid, d_in_ready} !== {exp_v, exp_r})
        begin failures++; $display("FAIL d_handshake src=%0d op=%0d beat=%0d: valid/ready=%b%b required %b%b",
          src, op, seen[src], d_out_valid, d_in_ready, exp_v, exp_r); end
      if (exp_v) begin
        checks++;
        if ({d_out_bits_size, d_out_bits_error} !== {3'(exp_size[src]), exp_e})
          begin failures++; $display("FAIL d_size_err src=%0d: size/error=%0d/%b required %0d/%b",
            src, d_out_bits_size, d_out_bits_error, exp_size[src], exp_e); end
        checks++;
        if ({d_out_bits_opcode, d_out_bits_param, d_out_bits_source, d_out_bits_data} !== {op, prm, src, dat})
          begin failures++; $display("FAIL d_pass src=%0d: got %h required %h", src,
            {d_out_bits_opcode, d_out_bits_param, d_out_bits_source, d_out_bits_data}, {op, prm, src, dat}); end
      end
      if (exp_r) begin
        done = 1'b1;
        if (op == 3'd0) acc_err[src] = last ? 1'b0 : (acc_err[src] | err);
        seen[src] = last ? 0 : seen[src] + 1;
      end
      tries++;
    end
    if (!done) begin
      checks++; failures++;
      $display("FAIL d_timeout src=%0d", src);
    end
    @(negedge clock);
    d_in_valid = 1'b0;
    #1;
    checks++;
    if (d_out_valid !== 1'b0)
      begin failures++; $display("FAIL d_idle: d_out_valid=%b required 0", d_out_valid); end
  endtask

  task automatic test_reset();
    apply_reset();
    // Size table starts at 0: a lone AccessAck is forwarded as size 0
    d_beat(2'd3, 3'd0, 1'b1, 0);
  endtask

  task automatic test_get_basic();
    send_msg(3'd4, 3'd2, 2'd1, 30'h100, 8'h5A, 0, 99);
    for (int i = 0; i < 4; i++) d_beat(2'd1, 3'd1, 1'b0, 0);
  endtask

  task automatic test_put_ack();
    send_msg(3'd0, 3'd1, 2'd3, 30'h20, 8'hAA, 0, 99);
    d_beat(2'd3, 3'd0, 1'b1, 0);
    d_beat(2'd3, 3'd0, 1'b0, 0);
  endtask

  task automatic test_get_size0();
    send_msg(3'd4, 3'd0, 2'd0, 30'h55, 8'h11, 0, 99);
    d_beat(2'd0, 3'd1, 1'b0, 0);
    send_msg(3'd4, 3'd1, 2'd0, 30'h60, 8'h22, 0, 99);
    d_beat(2'd0, 3'd1, 1'b0, 0);
    d_beat(2'd0, 3'd1, 1'b1, 0);
  endtask

  task automatic test_get_toggle();
    send_msg(3'd4, 3'd3, 2'd2, 30'h0, 8'h33, 1, 99);
    send_msg(3'd4, 3'd1, 2'd2, 30'h40, 8'h44, 0, 99);
  endtask

  task automatic test_other_opcode();
    send_msg(3'd2, 3'd2, 2'd3, 30'h80, 8'h66, 0, 99);
    send_msg(3'd5, 3'd3, 2'd3, 30'h88, 8'h67, 0, 99);
    send_msg(3'd0, 3'd1, 2'd3, 30'h90, 8'h68, 0, 99);
    d_beat(2'd3, 3'd0, 1'b0, 0);
    d_beat(2'd3, 3'd0, 1'b0, 0);
  endtask

  task automatic test_interleaved();
    send_msg(3'd4, 3'd1, 2'd0, 30'h10, 8'h77, 0, 99);
    send_msg(3'd0, 3'd1, 2'd2, 30'h30, 8'h88, 0, 99);
    d_beat(2'd0, 3'd1, 1'b0, 2);
    d_beat(2'd2, 3'd0, 1'b0, 2);
    d_beat(2'd0, 3'd1, 1'b0, 2);
    d_beat(2'd2, 3'd0, 1'b0, 2);
  endtask

  task automatic test_reset_mid();
    send_msg(3'd4, 3'd2, 2'd1, 30'h200, 8'h99, 0, 2);
    apply_reset();
    send_msg(3'd4, 3'd2, 2'd1, 30'h300, 8'h9A, 0, 99);
  endtask

  task automatic test_random();
    logic [2:0]  op;
    logic [2:0]  size;
    logic [1:0]  src;
    logic [29:0] base;
    int          sel;
    for (int m = 0; m < 24; m++) begin
      sel  = int'($urandom_range(0, 5));
      op   = (sel == 0) ? 3'd4 : (sel == 1) ? 3'd0 : (sel == 2) ? 3'd1 :
             (sel == 3) ? 3'd4 : (sel == 4) ? 3'd2 : 3'd3;
      size = (op == 3'd2 || op == 3'd3) ? 3'd0 : 3'($urandom_range(0, 3));
      src  = 2'($urandom);
      base = 30'($urandom) & ~30'((1 << size) - 1);
      send_msg(op, size, src, base, 8'($urandom), 2, 99);
      for (int b = 0; b < (1 << size); b++) begin
        if (op == 3'd0 || op == 3'd1) d_beat(src, 3'd0, 1'($urandom), 2);
        else                          d_beat(src, 3'd1, 1'($urandom), 2);
      end
    end
  endtask

  initial begin
    reset            = 1'b1;
    in_valid         = 1'b0;
    in_bits_opcode   = '0;
    in_bits_param    = '0;
    in_bits_size     = '0;
    in_bits_source   = '0;
    in_bits_address  = '0;
    in_bits_mask     = '0;
    in_bits_data     = '0;
    out_ready        = 1'b1;
    d_in_valid       = 1'b0;
    d_in_bits_opcode = '0;
    d_in_bits_param  = '0;
    d_in_bits_size   = '0;
    d_in_bits_source = '0;
    d_in_bits_data   = '0;
    d_in_bits_error  = 1'b0;
    d_out_ready      = 1'b1;
    model_reset();

    test_reset();
    test_get_basic();
    test_put_ack();
    test_get_size0();
    test_get_toggle();
    test_other_opcode();
    test_interleaved();
    test_reset_mid();
    test_random();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sirv_tl_fragmenter_8.md
Name: sirv_tl_fragmenter_8

Overview:
- TileLink-UL fragmenter control stage for an 8-bit (1-byte) peripheral bus.
- Sits directly downstream of the A-channel repeater and drives that repeater's rpt input.
- Splits multi-byte A requests into single-byte fragments with incrementing addresses.
- On the D channel, coalesces write acks back to one response per message and restores the original size on every response.

Parameters:
- MAX_LOG, 3, largest accepted log2(bytes) on in_bits_size; sets counter width.

Ports:
- clock  in  1  single clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- rpt  out  1  to repeater; 1 = hold current A beat for re-issue.
- in_ready  out  1  A-in ready (to repeater deq_ready).
- in_valid  in  1  A-in valid.
- in_bits_opcode/param/size  in  3/3/3  A-in fields.
- in_bits_source  in  2  A-in source.
- in_bits_address  in  30  A-in address, aligned to 2^size.
- in_bits_mask  in  1  A-in mask.
- in_bits_data  in  8  A-in data.
- out_ready  in  1  A-out ready.
- out_valid  out  1  A-out valid.
- out_bits_opcode/param/size/source/address/mask/data  out  3/3/3/2/30/1/8  A-out fields.
- d_in_ready  out  1  D-in ready.
- d_in_valid  in  1  D-in valid.
- d_in_bits_opcode/param/size/source/data/error  in  3/2/3/2/8/1  D-in fields.
- d_out_ready  in  1  D-out ready.
- d_out_valid  out  1  D-out valid.
- d_out_bits_opcode/param/size/source/data/error  out  3/2/3/2/8/1  D-out fields.

Behaviour:
- Reset (synchronous; clock and reset as decided):
  - a_cnt = 0; all per-source size entries = 0, beat counters = 0, sticky errors = 0.
  - rpt = 0 and out_valid = 0 whenever in_valid = 0. d_out_valid = 0 whenever d_in_valid = 0.
- A channel: purely combinational forward, zero latency.
  - out_valid = in_valid; in_ready = out_ready.
  - All out_bits fields = in_bits except:
    - out_bits_size = 0.
    - out_bits_address = in_bits_address | a_cnt, with a_cnt masked to the low in_bits_size bits.
- a_cnt (MAX_LOG bits) counts fragments of the current message.
  - a_last = (a_cnt == (1<<in_bits_size) - 1).
  - On out fire: a_last ? a_cnt <= 0 : a_cnt <= a_cnt + 1.
- Get (opcode 4):
  - rpt = in_valid & ~a_last; the repeater re-presents the same beat.
  - A Get of size N emits 2^N fragments from one upstream beat.
- PutFull/PutPartial (0/1): upstream already supplies 2^N beats; rpt = 0; a_cnt still advances the address.
- All other opcodes (2, 3, 5): treated as size 0 regardless of in_bits_size; single fragment; rpt = 0.
- size_tab[source] <= in_bits_size on out fire when a_cnt == 0 (first fragment).
- D channel, per-source beat counter d_cnt[s], last when d_cnt[s] == (1<<size_tab[s]) - 1.
  - AccessAckData (1):
    - Every beat forwarded: d_out_valid = d_in_valid, d_in_ready = d_out_ready.
    - d_out_bits_size = size_tab[s].
  - AccessAck (0), non-last beat:
    - d_in_ready = 1, d_out_valid = 0; beat is dropped.
    - err_tab[s] |= d_in_bits_error.
  - AccessAck (0), last beat:
    - Forwarded with size = size_tab[s] and error = d_in_bits_error | err_tab[s].
    - err_tab[s] cleared on fire.
  - On D-in fire, d_cnt[s] advances and wraps to 0 at last.
  - Other D opcodes pass through with size_tab[s].
- Simultaneous A first fragment and D last beat on different sources: both tables update independently.
- Same source in the same cycle: D reads the pre-write value. Protocol forbids source reuse before completion.
- Upstream guarantees in_bits_size <= MAX_LOG. The bench asserts this; RTL behaviour for larger sizes is undefined.
- Reset mid-message: counters and tables return to 0; upstream and downstream are reset together.

Decomposition:
- Shared package holds:
  - TL opcode constants: PUT_FULL=0, PUT_PARTIAL=1, ARITH=2, LOGIC=3, GET=4, HINT=5, ACK=0, ACK_DATA=1.
  - Field widths: 3/3/3/2/30/1/8.
- One sub-module: sirv_tl_frag_dtrack. It holds the per-source size_tab, d_cnt and err_tab, with an A-side write port and a D-side lookup/update port.

Test Plan:
- Get size 2, addr 0x100, src 1, out_ready = 1 → 4 out beats with addr 0x100..0x103, size 0; rpt = 1,1,1,0; in fires once per cycle.
- PutFull size 1, addr 0x20, data 0xAA, 0xBB → out addr 0x20, 0x21; rpt = 0. Two D AccessAck beats (error 1, 0) → one d_out with size 1, error 1.
- Get size 0 → single fragment, rpt = 0, a_cnt stays 0. AccessAckData d_out has size 0.
- Get size 3 with out_ready toggling 1,0 → address advances only on fire; 8 fragments 0x00..0x07; a_cnt = 0 afterward.
- Interleaved D: src 0 Get size 1 and src 2 PutFull size 1 responses interleaved → src 0 gets 2 AccessAckData beats size 1; src 2 gets a single AccessAck.
- Assert reset after 2 of 4 Get fragments → a_cnt = 0, rpt = 0 the next cycle; a new Get restarts at the base address.
